posit_add_normalize: RTL
========================

Name: posit_add_normalize

Overview:
- Normalisation stage of the posit adder, directly upstream of the rounding stage.
- Takes the raw signed-magnitude mantissa sum and the larger operand's combined scale (regime+exponent) from the adder core.
- Renormalises the sum so the hidden bit sits at a fixed position, adjusts the scale and forwards the flags.
- Output fields map one-to-one onto the rounding stage inputs E_normal, M_normal, sf, zero, inf, ZF. Two-stage pipeline with valid/ready handshake.

Parameters:
- N, 8, posit word width
- es, 4, exponent field width
- Bs, log2(N), scale bits above es; scale width SW = Bs+es+1
- W, N-es+4 (derived), input mantissa width {carry, hidden, fraction+guard[N-es+1:0]}

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept
- in_mant  in  W  unsigned magnitude sum, carry at bit W-1, hidden at W-2
- in_scale  in  SW  signed scale of larger operand
- in_sf, in_zero, in_inf  in  1 each  result sign, zero-operand-result, NaR flags
- out_valid  out  1  output word valid
- out_ready  in  1  rounding/consumer can accept
- E_normal  out  SW  signed normalised scale
- M_normal  out  W-2  fraction+guard bits, hidden bit removed
- sf, zero, inf, ZF  out  1 each  sign, zero, NaR, mantissa-sum-zero flags

Behaviour:
- Reset (async, rst_n=0): both stage valids = 0, out_valid=0, E_normal=0, M_normal=0, sf=zero=inf=ZF=0. in_ready = 1 one cycle after reset release. Reset mid-operation discards all in-flight words; nothing is emitted afterwards.
- Handshake: a transfer occurs on a rising clk when valid&ready. Outputs hold stable while out_valid & ~out_ready. in_ready = ~v1 | ~v2 | out_ready, combinational, no bubble at full throughput.
- Latency: exactly 2 cycles from input acceptance to out_valid with no backpressure. Throughput 1 word/cycle.
- Stage 1 registers the inputs and computes:
  - carry = in_mant[W-1]
  - lzc = leading-zero count of in_mant[W-2:0] (0..W-1)
  - mz = (in_mant == 0)
- Stage 2 produces the outputs:
  - carry=1: M_normal = in_mant[W-2:1] with bit0 ORed with dropped in_mant[0] (sticky); scale+1.
  - carry=0, mz=0: shift in_mant left by lzc; M_normal = shifted[W-3:0]; scale-lzc.
  - mz=1: ZF=1, M_normal=0, E_normal=0.
- Scale arithmetic is done in SW+1 bits, then saturated to the signed SW range [-2^(SW-1), 2^(SW-1)-1].
- Flags sf, zero, inf pass through unchanged, pipelined alongside the data.
- inf=1 forces M_normal=0 and E_normal=0, ZF=0.
- Simultaneous accept and emit in one cycle is legal and preserves order.
- Backpressure when both stages are full: in_ready=0; no word is dropped or duplicated.

Test Plan:
- Carry path: in_mant=8'b1000_0001, in_scale=5, sf=0 -> after 2 cycles E_normal=6, M_normal=6'b000001 (sticky), ZF=0.
- Left normalise: in_mant=8'b0000_0101, in_scale=10 -> E_normal=6, M_normal=6'b010000. in_mant=8'b0100_0000, in_scale=3 -> E_normal=3, M_normal=0.
- Zero/flags: in_mant=0 -> ZF=1, E_normal=0, M_normal=0. in_inf=1 with any mantissa -> inf=1, E_normal=0, M_normal=0. in_sf=1 passes through to sf=1.
- Saturation: in_scale=127 with carry -> E_normal=127. in_scale=-128 with in_mant=8'b0000_0001 -> E_normal=-128.
- Backpressure: stream 5 words with out_ready low for 4 cycles mid-stream -> in_ready drops after 2 words are buffered, outputs stay stable, all 5 words emerge in order, none lost or duplicated.
- Reset mid-flight: assert rst_n=0 with 2 words in flight -> all outputs 0 immediately, out_valid stays 0 until new input is accepted after release.

Source files
------------

// File: rtl/posit_add_normalize.sv
// Posit adder normalisation stage: renormalises the raw mantissa sum so the hidden
// bit sits at a fixed position, adjusts and saturates the scale, and forwards flags.
module posit_add_normalize #(
  parameter int N  = 8,
  parameter int es = 4,
  parameter int Bs = $clog2(N),
  parameter int SW = Bs + es + 1,
  parameter int W  = N - es + 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_mant,
  input  logic [SW-1:0] in_scale,
  input  logic          in_sf,
  input  logic          in_zero,
  input  logic          in_inf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] E_normal,
  output logic [W-3:0]  M_normal,
  output logic          sf,
  output logic          zero,
  output logic          inf,
  output logic          ZF
);

  localparam int LZW = $clog2(W);

  // Stage 1 registers
  logic           v1_q, v1_d;
  logic [W-1:0]   mant1_q, mant1_d;
  logic [SW-1:0]  scale1_q, scale1_d;
  logic           sf1_q, sf1_d, zero1_q, zero1_d, inf1_q, inf1_d;
  logic           carry1_q, carry1_d, mz1_q, mz1_d;
  logic [LZW-1:0] lzc1_q, lzc1_d;

  // Stage 2 (output) registers
  logic           v2_q, v2_d;
  logic [SW-1:0]  e_normal_q, e_normal_d;
  logic [W-3:0]   m_normal_q, m_normal_d;
  logic           sf_q, sf_d, zero_q, zero_d, inf_q, inf_d, zf_q, zf_d;

  // Held low through reset so nothing is accepted until the first clock after release
  logic           rdy_q, rdy_d;

  logic           in_fire, adv2, out_fire;
  logic [LZW-1:0] lzc_in;
  logic [W-1:0]   shifted;
  logic [SW:0]    scale_ext, scale_sum;

  assign in_ready = rdy_q & (~v1_q | ~v2_q | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign adv2     = v1_q & (~v2_q | out_ready);
  assign out_fire = v2_q & out_ready;

  always_comb begin
    lzc_in = LZW'(W - 1);
    for (int i = 0; i <= W - 2; i++) begin
      if (in_mant[i]) lzc_in = LZW'(W - 2 - i);
    end
  end

  always_comb begin
    rdy_d    = 1'b1;
    v1_d     = v1_q;
    mant1_d  = mant1_q;
    scale1_d = scale1_q;
    sf1_d    = sf1_q;
    zero1_d  = zero1_q;
    inf1_d   = inf1_q;
    carry1_d = carry1_q;
    mz1_d    = mz1_q;
    lzc1_d   = lzc1_q;
    if (in_fire) begin
      v1_d     = 1'b1;
      mant1_d  = in_mant;
      scale1_d = in_scale;
      sf1_d    = in_sf;
      zero1_d  = in_zero;
      inf1_d   = in_inf;
      carry1_d = in_mant[W-1];
      mz1_d    = (in_mant == '0);
      lzc1_d   = lzc_in;
    end else if (adv2) begin
      v1_d = 1'b0;
    end
  end

  // Scale is widened by one bit so +1 / -lzc cannot wrap before saturation
  always_comb begin
    shifted    = mant1_q << lzc1_q;
    scale_ext  = {scale1_q[SW-1], scale1_q};
    scale_sum  = '0;
    v2_d       = v2_q;
    e_normal_d = e_normal_q;
    m_normal_d = m_normal_q;
    sf_d       = sf_q;
    zero_d     = zero_q;
    inf_d      = inf_q;
    zf_d       = zf_q;
    if (adv2) begin
      v2_d   = 1'b1;
      sf_d   = sf1_q;
      zero_d = zero1_q;
      inf_d  = inf1_q;
      zf_d   = 1'b0;
      if (inf1_q) begin
        e_normal_d = '0;
        m_normal_d = '0;
      end else if (mz1_q) begin
        e_normal_d = '0;
        m_normal_d = '0;
        zf_d       = 1'b1;
      end else begin
        if (carry1_q) begin
          m_normal_d = {mant1_q[W-2:2], mant1_q[1] | mant1_q[0]};
          scale_sum  = scale_ext + (SW+1)'(1);
        end else begin
          m_normal_d = shifted[W-3:0];
          scale_sum  = scale_ext - {{(SW+1-LZW){1'b0}}, lzc1_q};
        end
        if (scale_sum[SW] != scale_sum[SW-1])
          e_normal_d = scale_sum[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        else
          e_normal_d = scale_sum[SW-1:0];
      end
    end else if (out_fire) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      v1_q       <= 1'b0;
      mant1_q    <= '0;
      scale1_q   <= '0;
      sf1_q      <= 1'b0;
      zero1_q    <= 1'b0;
      inf1_q     <= 1'b0;
      carry1_q   <= 1'b0;
      mz1_q      <= 1'b0;
      lzc1_q     <= '0;
      v2_q       <= 1'b0;
      e_normal_q <= '0;
      m_normal_q <= '0;
      sf_q       <= 1'b0;
      zero_q     <= 1'b0;
      inf_q      <= 1'b0;
      zf_q       <= 1'b0;
    end else begin
      rdy_q      <= rdy_d;
      v1_q       <= v1_d;
      mant1_q    <= mant1_d;
      scale1_q   <= scale1_d;
      sf1_q      <= sf1_d;
      zero1_q    <= zero1_d;
      inf1_q     <= inf1_d;
      carry1_q   <= carry1_d;
      mz1_q      <= mz1_d;
      lzc1_q     <= lzc1_d;
      v2_q       <= v2_d;
      e_normal_q <= e_normal_d;
      m_normal_q <= m_normal_d;
      sf_q       <= sf_d;
      zero_q     <= zero_d;
      inf_q      <= inf_d;
      zf_q       <= zf_d;
    end
  end

  assign out_valid = v2_q;
  assign E_normal  = e_normal_q;
  assign M_normal  = m_normal_q;
  assign sf        = sf_q;
  assign zero      = zero_q;
  assign inf       = inf_q;
  assign ZF        = zf_q;

endmodule
